// File: rtl/sign_dot_pipe.sv
// Streams operand pairs, accumulates their products per frame and reports sign/zero of the frame sum.
// Latency: a term captured at edge E1 has its result registered at edge E3 (out_valid high the cycle after E3).
// No backpressure: a new term is accepted every cycle; idle cycles simply hold the accumulator.
module sign_dot_pipe #(
    parameter int W      = 11,
    parameter int DEPTH  = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         re,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    output logic         s,
    output logic         z,
    output logic         out_valid,
    output logic         frame_err
);

    // Accumulator width is sized so DEPTH extreme products can never wrap.
    localparam int ACC_W = 2*W + $clog2(DEPTH) + 1;
    localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = 2*W;

    // Stage 1 registers
    logic         v1;
    logic         last1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;

    // Stage 2 registers
    logic          v2;
    logic          last2;
    logic [PW-1:0] p2;

    // Stage 3 state
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             first;

    // Combinational helpers
    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] ext_p;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;
    logic             close;
    logic             sum_zero;
    logic             sum_pos;

    // Stage 1: capture an incoming term; operands only load when valid to avoid needless toggling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            a1    <= '0;
            b1    <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a1    <= i1;
                b1    <= i2;
                last1 <= re;
            end
        end
    end

    // Extending both operands to 2W before multiplying gives the exact 2W-bit product
    // for both two's complement (sign extension) and unsigned (zero extension) operands.
    always_comb begin
        prod = {{W{SIGNED & a1[W-1]}}, a1} * {{W{SIGNED & b1[W-1]}}, b1};
    end

    // Stage 2: register the product alongside the valid and last-term flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2    <= 1'b0;
            last2 <= 1'b0;
            p2    <= '0;
        end else begin
            v2    <= v1;
            last2 <= last1;
            if (v1) begin
                p2 <= prod;
            end
        end
    end

    // Stage 3 datapath: the first term of a frame ignores whatever is left in acc.
    always_comb begin
        ext_p    = {{(ACC_W-PW){SIGNED & p2[PW-1]}}, p2};
        base     = first ? '0 : acc;
        sum      = base + ext_p;
        sum_zero = (sum == '0);
        sum_pos  = SIGNED ? (!sum[ACC_W-1] && !sum_zero) : !sum_zero;
        close    = last2 || (cnt == CW'(DEPTH-1));
    end

    // Stage 3: accumulate, or on frame close publish the result and rearm for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            cnt       <= '0;
            first     <= 1'b1;
            s         <= 1'b0;
            z         <= 1'b0;
            frame_err <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (v2) begin
                if (close) begin
                    s         <= sum_pos;
                    z         <= sum_zero;
                    frame_err <= ~last2;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    first     <= 1'b1;
                end else begin
                    acc   <= sum;
                    cnt   <= cnt + CW'(1);
                    first <= 1'b0;
                end
            end
        end
    end

endmodule
